// File: rtl/trig_clk_enable_seq.sv
// trig_clk_enable_seq
// Multi-channel trigger-aligned clock-enable generator. Each channel waits
// for a rising edge on its trigger, waits a programmable delay, then emits a
// train of one-cycle clk_en strobes spaced divide+1 cycles apart. The train
// ends after pulse_count strobes (with a one-cycle done pulse), or runs until
// stop when continuous mode was latched at the trigger.
module trig_clk_enable_seq #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8,
    parameter int DLY_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] trigger,
    input  logic [DIV_W-1:0]  divide,
    input  logic [DLY_W-1:0]  start_delay,
    input  logic [CNT_W-1:0]  pulse_count,
    input  logic              continuous,
    input  logic              stop,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Control state (reset)
    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [NUM_CH-1:0] trig_q;
    logic [NUM_CH-1:0] trig_d;
    logic [NUM_CH-1:0] armed_q;
    logic [NUM_CH-1:0] armed_d;
    logic [NUM_CH-1:0] clk_en_q;
    logic [NUM_CH-1:0] clk_en_d;
    logic [NUM_CH-1:0] busy_q;
    logic [NUM_CH-1:0] busy_d;
    logic [NUM_CH-1:0] done_q;
    logic [NUM_CH-1:0] done_d;

    // Per-channel latched configuration and counters (no reset needed:
    // they are always loaded before being consulted)
    logic [DIV_W-1:0]  div_val_q [NUM_CH];
    logic [DIV_W-1:0]  div_val_d [NUM_CH];
    logic [DIV_W-1:0]  div_cnt_q [NUM_CH];
    logic [DIV_W-1:0]  div_cnt_d [NUM_CH];
    logic [DLY_W-1:0]  dly_cnt_q [NUM_CH];
    logic [DLY_W-1:0]  dly_cnt_d [NUM_CH];
    logic [CNT_W-1:0]  rem_q     [NUM_CH];
    logic [CNT_W-1:0]  rem_d     [NUM_CH];
    logic [NUM_CH-1:0] cont_q;
    logic [NUM_CH-1:0] cont_d;

    // A trigger held high across reset release must not look like an edge.
    // armed_q stays low for the first post-reset edge so that edge only
    // primes the trigger history.
    logic [NUM_CH-1:0] trig_edge;

    // Rising-edge detection on the already-synchronous trigger inputs
    always_comb begin
        trig_d    = trigger;
        armed_d   = '1;
        trig_edge = trigger & ~trig_q & armed_q;
    end

    // Next-state logic for every channel's IDLE/DELAY/RUN sequencer
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]   = state_q[i];
            clk_en_d[i]  = 1'b0;
            busy_d[i]    = busy_q[i];
            done_d[i]    = 1'b0;
            div_val_d[i] = div_val_q[i];
            div_cnt_d[i] = div_cnt_q[i];
            dly_cnt_d[i] = dly_cnt_q[i];
            rem_d[i]     = rem_q[i];
            cont_d[i]    = cont_q[i];

            if (stop) begin
                // Global abort wins over everything, including a fresh edge
                state_d[i] = ST_IDLE;
                busy_d[i]  = 1'b0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        busy_d[i] = 1'b0;
                        if (trig_edge[i]) begin
                            div_val_d[i] = divide;
                            div_cnt_d[i] = '0;
                            dly_cnt_d[i] = start_delay;
                            rem_d[i]     = pulse_count;
                            cont_d[i]    = continuous;
                            busy_d[i]    = 1'b1;
                            state_d[i]   = (start_delay != '0) ? ST_DELAY : ST_RUN;
                        end
                    end

                    ST_DELAY: begin
                        busy_d[i] = 1'b1;
                        // Entering RUN on the D-th edge puts the first strobe
                        // one edge later, i.e. D+1 edges after detection.
                        if (dly_cnt_q[i] <= DLY_W'(1)) begin
                            state_d[i] = ST_RUN;
                        end else begin
                            dly_cnt_d[i] = dly_cnt_q[i] - DLY_W'(1);
                        end
                    end

                    ST_RUN: begin
                        busy_d[i] = 1'b1;
                        if (!cont_q[i] && (rem_q[i] == '0)) begin
                            // Last strobe already issued (or none requested)
                            state_d[i] = ST_IDLE;
                            busy_d[i]  = 1'b0;
                            done_d[i]  = 1'b1;
                        end else if (div_cnt_q[i] == '0) begin
                            clk_en_d[i]  = 1'b1;
                            div_cnt_d[i] = div_val_q[i];
                            if (!cont_q[i]) begin
                                rem_d[i] = rem_q[i] - CNT_W'(1);
                            end
                        end else begin
                            div_cnt_d[i] = div_cnt_q[i] - DIV_W'(1);
                        end
                    end

                    default: begin
                        state_d[i] = ST_IDLE;
                        busy_d[i]  = 1'b0;
                    end
                endcase
            end
        end
    end

    // Control registers: FSM state, trigger history and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
            end
            trig_q   <= '0;
            armed_q  <= '0;
            clk_en_q <= '0;
            busy_q   <= '0;
            done_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
            end
            trig_q   <= trig_d;
            armed_q  <= armed_d;
            clk_en_q <= clk_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Datapath registers: latched config and period/delay/pulse counters
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            div_val_q[i] <= div_val_d[i];
            div_cnt_q[i] <= div_cnt_d[i];
            dly_cnt_q[i] <= dly_cnt_d[i];
            rem_q[i]     <= rem_d[i];
        end
        cont_q <= cont_d;
    end

    assign clk_en = clk_en_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_trig_clk_enable_seq.sv
// Directed bench for trig_clk_enable_seq. Cycle index c counts edges after
// the trigger is presented; c=0 is the detection edge N. Outputs are sampled
// 1 ns after each rising edge.
module tb_trig_clk_enable_seq;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;
    localparam int DLY_W  = 8;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] trigger;
    logic [DIV_W-1:0]  divide;
    logic [DLY_W-1:0]  start_delay;
    logic [CNT_W-1:0]  pulse_count;
    logic              continuous;
    logic              stop;
    logic [NUM_CH-1:0] clk_en;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;

    int vectors;
    int miscompares;

    trig_clk_enable_seq #(
        .NUM_CH(NUM_CH),
        .DIV_W (DIV_W),
        .DLY_W (DLY_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .divide     (divide),
        .start_delay(start_delay),
        .pulse_count(pulse_count),
        .continuous (continuous),
        .stop       (stop),
        .clk_en     (clk_en),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Reset clears outputs; a trigger held high through release is no edge
    task automatic test_reset();
        rst = 1'b1;
        trigger = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            step();
            vectors++;
            if ({clk_en, busy, done} !== 12'h000) begin
                miscompares++;
                $display("FAIL reset c=%0d: en/busy/done=%b/%b/%b required 0000/0000/0000", c, clk_en, busy, done);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            vectors++;
            if ({clk_en, busy, done} !== 12'h000) begin
                miscompares++;
                $display("FAIL held_trigger c=%0d: en/busy/done=%b/%b/%b required 0000/0000/0000", c, clk_en, busy, done);
            end
        end
        trigger = '0;
        idle(2);
    endtask

    // divide=0, delay=0, count=3 on ch0: strobes at N+1..N+3, done at N+4
    task automatic test_basic();
        logic [3:0] e_en, e_busy, e_done;
        divide = 8'd0; start_delay = 8'd0; pulse_count = 16'd3; continuous = 1'b0;
        trigger[0] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step();
            e_en   = (c >= 1 && c <= 3) ? 4'b0001 : 4'b0000;
            e_busy = (c <= 3) ? 4'b0001 : 4'b0000;
            e_done = (c == 4) ? 4'b0001 : 4'b0000;
            vectors++;
            if ({clk_en, busy, done} !== {e_en, e_busy, e_done}) begin
                miscompares++;
                $display("FAIL basic c=%0d: en/busy/done=%b/%b/%b required %b/%b/%b", c, clk_en, busy, done, e_en, e_busy, e_done);
            end
        end
        trigger = '0;
        idle(3);
    endtask

    // divide=2, delay=4, count=4 on ch1: strobes at N+5,8,11,14, done N+15
    task automatic test_div_delay();
        logic [3:0] e_en, e_busy, e_done;
        divide = 8'd2; start_delay = 8'd4; pulse_count = 16'd4; continuous = 1'b0;
        trigger[1] = 1'b1;
        for (int c = 0; c < 18; c++) begin
            step();
            e_en   = (c == 5 || c == 8 || c == 11 || c == 14) ? 4'b0010 : 4'b0000;
            e_busy = (c <= 14) ? 4'b0010 : 4'b0000;
            e_done = (c == 15) ? 4'b0010 : 4'b0000;
            vectors++;
            if ({clk_en, busy, done} !== {e_en, e_busy, e_done}) begin
                miscompares++;
                $display("FAIL div_delay c=%0d: en/busy/done=%b/%b/%b required %b/%b/%b", c, clk_en, busy, done, e_en, e_busy, e_done);
            end
        end
        trigger = '0;
        idle(3);
    endtask

    // Continuous ch2 with divide=1; stop at N+20 together with a ch3 trigger
    task automatic test_cont_stop();
        logic [3:0] e_en, e_busy, e_done;
        divide = 8'd1; start_delay = 8'd0; pulse_count = 16'd0; continuous = 1'b1;
        trigger[2] = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (c == 20) begin
                stop = 1'b1;
                trigger[3] = 1'b1;
            end
            if (c == 21) stop = 1'b0;
            step();
            e_en   = (c >= 1 && c < 20 && (c % 2) == 1) ? 4'b0100 : 4'b0000;
            e_busy = (c < 20) ? 4'b0100 : 4'b0000;
            e_done = 4'b0000;
            vectors++;
            if ({clk_en, busy, done} !== {e_en, e_busy, e_done}) begin
                miscompares++;
                $display("FAIL cont_stop c=%0d: en/busy/done=%b/%b/%b required %b/%b/%b", c, clk_en, busy, done, e_en, e_busy, e_done);
            end
        end
        continuous = 1'b0;
        trigger = '0;
        idle(3);
    endtask

    // ch0 divide=1, delay=2, count=3; re-trigger and config changes mid-train
    task automatic test_retrigger();
        logic [3:0] e_en, e_busy, e_done;
        divide = 8'd1; start_delay = 8'd2; pulse_count = 16'd3; continuous = 1'b0;
        trigger[0] = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c == 2) trigger[0] = 1'b0;
            if (c == 3) divide = 8'd5;
            if (c == 4) trigger[0] = 1'b1;
            if (c == 6) begin
                pulse_count = 16'd9;
                start_delay = 8'd0;
            end
            step();
            e_en   = (c == 3 || c == 5 || c == 7) ? 4'b0001 : 4'b0000;
            e_busy = (c <= 7) ? 4'b0001 : 4'b0000;
            e_done = (c == 8) ? 4'b0001 : 4'b0000;
            vectors++;
            if ({clk_en, busy, done} !== {e_en, e_busy, e_done}) begin
                miscompares++;
                $display("FAIL retrigger c=%0d: en/busy/done=%b/%b/%b required %b/%b/%b", c, clk_en, busy, done, e_en, e_busy, e_done);
            end
        end
        trigger = '0;
        idle(3);
    endtask

    // All four channels triggered together: divide=1, delay=1, count=5
    task automatic test_multi_align();
        logic [3:0] e_en, e_busy, e_done;
        divide = 8'd1; start_delay = 8'd1; pulse_count = 16'd5; continuous = 1'b0;
        trigger = 4'b1111;
        for (int c = 0; c < 14; c++) begin
            step();
            e_en   = (c >= 2 && c <= 10 && (c % 2) == 0) ? 4'b1111 : 4'b0000;
            e_busy = (c <= 10) ? 4'b1111 : 4'b0000;
            e_done = (c == 11) ? 4'b1111 : 4'b0000;
            vectors++;
            if ({clk_en, busy, done} !== {e_en, e_busy, e_done}) begin
                miscompares++;
                $display("FAIL multi_align c=%0d: en/busy/done=%b/%b/%b required %b/%b/%b", c, clk_en, busy, done, e_en, e_busy, e_done);
            end
        end
        trigger = '0;
        idle(3);
    endtask

    // pulse_count=0 with delay=3 on ch1: no strobes, done at N+4
    task automatic test_zero_count();
        logic [3:0] e_en, e_busy, e_done;
        divide = 8'd0; start_delay = 8'd3; pulse_count = 16'd0; continuous = 1'b0;
        trigger[1] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            step();
            e_en   = 4'b0000;
            e_busy = (c <= 3) ? 4'b0010 : 4'b0000;
            e_done = (c == 4) ? 4'b0010 : 4'b0000;
            vectors++;
            if ({clk_en, busy, done} !== {e_en, e_busy, e_done}) begin
                miscompares++;
                $display("FAIL zero_count c=%0d: en/busy/done=%b/%b/%b required %b/%b/%b", c, clk_en, busy, done, e_en, e_busy, e_done);
            end
        end
        trigger = '0;
        idle(3);
    endtask

    // divide=8'hFF, count=2 on ch3: strobes at N+1 and N+257, done N+258
    task automatic test_max_divide();
        logic [3:0] e_en, e_busy, e_done;
        divide = 8'hFF; start_delay = 8'd0; pulse_count = 16'd2; continuous = 1'b0;
        trigger[3] = 1'b1;
        for (int c = 0; c < 261; c++) begin
            step();
            e_en   = (c == 1 || c == 257) ? 4'b1000 : 4'b0000;
            e_busy = (c <= 257) ? 4'b1000 : 4'b0000;
            e_done = (c == 258) ? 4'b1000 : 4'b0000;
            vectors++;
            if ({clk_en, busy, done} !== {e_en, e_busy, e_done}) begin
                miscompares++;
                $display("FAIL max_divide c=%0d: en/busy/done=%b/%b/%b required %b/%b/%b", c, clk_en, busy, done, e_en, e_busy, e_done);
            end
        end
        trigger = '0;
        idle(3);
    endtask

    // rst during DELAY on ch2 clears everything; trigger held through release
    task automatic test_rst_mid_delay();
        logic [3:0] e_en, e_busy, e_done;
        divide = 8'd0; start_delay = 8'd10; pulse_count = 16'd1; continuous = 1'b0;
        trigger[2] = 1'b1;
        for (int c = 0; c < 26; c++) begin
            if (c == 3) rst = 1'b1;
            if (c == 5) rst = 1'b0;
            step();
            e_en   = 4'b0000;
            e_busy = (c <= 2) ? 4'b0100 : 4'b0000;
            e_done = 4'b0000;
            vectors++;
            if ({clk_en, busy, done} !== {e_en, e_busy, e_done}) begin
                miscompares++;
                $display("FAIL rst_mid_delay c=%0d: en/busy/done=%b/%b/%b required %b/%b/%b", c, clk_en, busy, done, e_en, e_busy, e_done);
            end
        end
        trigger = '0;
        idle(3);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        trigger     = '0;
        divide      = '0;
        start_delay = '0;
        pulse_count = '0;
        continuous  = 1'b0;
        stop        = 1'b0;

        test_reset();
        test_basic();
        test_div_delay();
        test_cont_stop();
        test_retrigger();
        test_multi_align();
        test_zero_count();
        test_max_divide();
        test_rst_mid_delay();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/trig_clk_enable_seq.md
Name: trig_clk_enable_seq

Overview:
- Multi-channel, trigger-aligned clock-enable generator; next generation of the single-channel trigger/clock corrector.
- Derives no new clocks. Each channel produces a one-cycle `clk_en` strobe train on the system clock.
  - Train starts a programmable delay after a trigger rising edge.
  - Strobe spacing is programmable: one strobe every `divide+1` cycles.
  - Train stops after a programmed pulse count, or runs until stopped in continuous mode.
- Sits between the controller's start signals and the multiply cores, so cores start in lock-step with a known phase.

Parameters:
- NUM_CH, 4, number of independent channels
- DIV_W, 8, width of the divide setting
- DLY_W, 8, width of the start-delay setting
- CNT_W, 16, width of the pulse-count setting

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- trigger  in  NUM_CH  per-channel start request; rising-edge sensitive, asynchronous-free (already in clk domain)
- divide  in  DIV_W  strobe period minus one, shared by all channels
- start_delay  in  DLY_W  cycles between trigger detection and first strobe window, shared
- pulse_count  in  CNT_W  number of strobes per one-shot train, shared
- continuous  in  1  1 = ignore pulse_count, run until stop
- stop  in  1  abort all channels
- clk_en  out  NUM_CH  per-channel one-cycle enable strobe (registered)
- busy  out  NUM_CH  channel in DELAY or RUN (registered)
- done  out  NUM_CH  one-cycle pulse when a one-shot train completes (registered)

Behaviour:
- Reset: `clk_en`, `busy`, `done` = 0; all channels IDLE; trigger history registers = 0. A trigger already high when rst deasserts is not an edge.
- Edge detect: `trig_q` is registered per channel. An edge at edge N means `trigger` is sampled 1 at edge N and was 0 at edge N-1.
- Per-channel FSM: IDLE, DELAY, RUN.
- IDLE:
  - On edge at clock edge N, latch `divide`, `start_delay`, `pulse_count` and `continuous` into channel registers. Later input changes do not affect a running train.
  - Go to DELAY if `start_delay` != 0, else RUN. `busy` = 1 from edge N.
- DELAY: counts D = latched `start_delay` cycles, then goes to RUN.
- RUN:
  - First `clk_en` high for exactly the cycle beginning at edge N+1+D.
  - Subsequent strobes at N+1+D+k*(V+1), where V = latched `divide`. V=0 gives a strobe every cycle.
  - `clk_en` is never high for two consecutive cycles unless V=0.
- One-shot completion (continuous=0):
  - After the C-th strobe (C = latched `pulse_count`), return to IDLE at the next edge.
  - At that same edge: `busy` falls and `done` is high for one cycle.
  - C=0: no strobes. The channel enters IDLE with the `done` pulse one cycle after the DELAY phase would end.
- Continuous: strobes indefinitely; `done` never asserts.
- stop:
  - Sampled 1 at any edge: every non-IDLE channel goes IDLE at that edge.
  - At that edge `clk_en` and `busy` → 0; no `done`.
  - stop has priority over a trigger edge in the same cycle (that edge is discarded).
- Re-trigger: trigger edges while a channel is busy are ignored and are not queued.
- Done then trigger: a trigger edge sampled at the same edge the channel returns to IDLE is ignored. A trigger must arrive at least one cycle after `done`.
- Channels are fully independent except for shared config inputs and global stop. Simultaneous triggers on several channels produce phase-identical trains.
- Counters: delay, divide and pulse counters saturate-free. Each reloads on its own period; no wrap-around artefacts at max values. V = 2^DIV_W-1 gives a period of 2^DIV_W cycles.
- rst mid-train: all channels IDLE next edge, outputs 0, no `done`.

Test Plan:
- Basic one-shot:
  - Stimulus: clk 10 ns, rst high to 20 ns; divide=0, start_delay=0, pulse_count=3; trigger[0] rises at 25 ns.
  - Expect: `clk_en[0]` high 3 consecutive cycles starting the second edge after trigger sampling; `done[0]` for 1 cycle after; `busy[0]` covers exactly the train.
- Divide and delay: divide=2, start_delay=4, pulse_count=4 on ch1 → first strobe 5 cycles after detection, strobes spaced 3 cycles, `done` after the 4th.
- Continuous and stop:
  - Stimulus: continuous=1, divide=1 on ch2; assert stop 20 cycles later, simultaneous with a trigger on ch3.
  - Expect: strobes every other cycle until stop; `clk_en`/`busy` drop at that edge; no `done`; ch3 stays IDLE.
- Re-trigger and config change:
  - Stimulus: pulse and re-pulse trigger[0] mid-train; change divide mid-train.
  - Expect: train unaffected, single `done`, latched divide used.
- Multi-channel alignment: trigger all 4 channels same cycle, pulse_count=5 → identical `clk_en` vectors (4'b1111 or 0 every cycle).
- Boundaries:
  - pulse_count=0 → no strobes, single `done`.
  - divide=8'hFF → 256-cycle spacing.
  - rst mid-DELAY → all outputs 0 next edge.
  - trigger held high through rst release → no train.
